// File: rtl/instr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_sequencer : program memory that issues words to simple_processor     |
// |                   one at a time over the DIN/Run/Done handshake            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module instr_sequencer #(
    parameter int BITS    = 16,
    parameter int ADDR    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Wr_en,
    input  logic [ADDR-1:0] Wr_addr,
    input  logic [BITS-1:0] Wr_data,
    input  logic [ADDR:0]   Prog_len,
    input  logic            Start,
    input  logic            Done,
    output logic [BITS-1:0] DIN,
    output logic            Run,
    output logic            Busy,
    output logic            Finished,
    output logic            Err,
    output logic [ADDR-1:0] PC
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam int            DEPTH   = 1 << ADDR;
    localparam logic [ADDR:0] DEPTH_W = DEPTH[ADDR:0];
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [BITS-1:0] mem [DEPTH];
    logic [ADDR-1:0] pc_nx, pc_inc;
    logic [BITS-1:0] din_nx;
    logic [ADDR:0]   len, len_nx, len_clamped;
    logic [CW-1:0]   wdog, wdog_nx;
    logic            idle_like;

    assign idle_like   = (state == S_IDLE) || (state == S_FINISH) || (state == S_ERROR);
    assign len_clamped = (Prog_len > DEPTH_W) ? DEPTH_W : Prog_len;
    assign pc_inc      = PC + ADDR'(1);

    always_ff @(posedge Clock) begin
        if (Wr_en && idle_like)
            mem[Wr_addr] <= Wr_data;
    end

    always_comb begin
        state_nx = state;
        pc_nx    = PC;
        din_nx   = DIN;
        len_nx   = len;
        wdog_nx  = wdog;
        case (state)
            S_IDLE, S_FINISH, S_ERROR: begin
                if (Start) begin
                    len_nx  = len_clamped;
                    pc_nx   = '0;
                    wdog_nx = '0;
                    if (len_clamped == '0) begin
                        state_nx = S_FINISH;
                        din_nx   = '0;
                    end else begin
                        state_nx = S_ISSUE;
                        // A write landing on address 0 in this same cycle must reach the first issue
                        din_nx   = (Wr_en && (Wr_addr == '0)) ? Wr_data : mem[0];
                    end
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
                wdog_nx  = '0;
            end
            S_WAIT: begin
                if (Done) begin
                    if ({1'b0, PC} == len - (ADDR+1)'(1)) begin
                        state_nx = S_FINISH;
                        din_nx   = '0;
                    end else begin
                        state_nx = S_ISSUE;
                        pc_nx    = pc_inc;
                        din_nx   = mem[pc_inc];
                    end
                end else if (wdog == WD_LAST) begin
                    state_nx = S_ERROR;
                    din_nx   = '0;
                end else begin
                    wdog_nx = wdog + CW'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                din_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            PC       <= '0;
            DIN      <= '0;
            len      <= '0;
            wdog     <= '0;
            Run      <= 1'b0;
            Busy     <= 1'b0;
            Finished <= 1'b0;
            Err      <= 1'b0;
        end else begin
            state    <= state_nx;
            PC       <= pc_nx;
            DIN      <= din_nx;
            len      <= len_nx;
            wdog     <= wdog_nx;
            Run      <= (state_nx == S_ISSUE);
            Busy     <= (state_nx == S_ISSUE) || (state_nx == S_WAIT);
            Finished <= (state_nx == S_FINISH);
            Err      <= (state_nx == S_ERROR);
        end
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

- Program-side initiator for `simple_processor`: holds a small instruction memory and issues its words one at a time over the processor's `DIN`/`Run`/`Done` handshake.
- Each instruction is presented for exactly one `Run` cycle; the sequencer then waits for `Done` before issuing the next one.
- A per-instruction watchdog flags a processor that never completes.
- Sits between the test/host logic that loads programs and the processor's `DIN`/`Run` inputs.

## Interface
- `BITS`, 16, instruction word width; equals the processor's `BITS`.
- `ADDR`, 4, program-memory address width; depth is 2^ADDR words.
- `TIMEOUT`, 15, max WAIT cycles without `Done` before error (≥1).
- `Clock`  in  1  single clock; all state on rising edge.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `Wr_en`  in  1  program-memory write strobe.
- `Wr_addr`  in  ADDR  write address.
- `Wr_data`  in  BITS  instruction word to store.
- `Prog_len`  in  ADDR+1  number of words to execute (0..2^ADDR); sampled on `Start`.
- `Start`  in  1  begin execution at address 0.
- `Done`  in  1  processor completion pulse.
- `DIN`  out  BITS  instruction word to processor.
- `Run`  out  1  instruction-valid strobe to processor.
- `Busy`  out  1  high in ISSUE/WAIT.
- `Finished`  out  1  high in FINISH.
- `Err`  out  1  high in ERROR.
- `PC`  out  ADDR  address of the current or last issued word.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH, ERROR.
- Reset (async, `Resetn`=0): state IDLE, `PC`=0, `DIN`=0, `Run`=0, `Busy`=0, `Finished`=0, `Err`=0, internal length and watchdog registers cleared.
  - Memory contents are not reset.
- Memory writes are accepted only in IDLE, FINISH and ERROR. `Wr_en` is ignored in ISSUE/WAIT.
- IDLE/FINISH/ERROR + `Start`=1:
  - Latch `Prog_len`, set `PC`=0, clear `Finished`/`Err`.
  - If `Prog_len`=0, go to FINISH.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `Run`=1, `DIN`=mem[`PC`].
  - `Done` is ignored in this cycle.
  - Go to WAIT with the watchdog counter cleared.
- WAIT:
  - `Run`=0, `DIN` held at mem[`PC`].
  - On `Done`=1:
    - If `PC`=len−1, go to FINISH (`PC` holds).
    - Otherwise `PC`+1 and go to ISSUE.
  - Without `Done`: the counter increments; when it reaches `TIMEOUT`, go to ERROR.
- FINISH / ERROR:
  - `DIN`=0, `Run`=0.
  - Hold until `Start` or reset.
- `Start` while `Busy` is ignored.
- `Start` and `Wr_en` in the same idle cycle: the write completes and execution starts. A write to address 0 is seen by the first issue.
- `Prog_len` > 2^ADDR is clamped to 2^ADDR.
- `PC` never wraps during a run.

## Timing
- `Start` sampled at edge k → `Run`=1 during cycle k+1.
- `Run` is high for exactly one cycle per instruction and is never high two consecutive cycles.
- `Done` sampled at edge m (in WAIT) → next `Run`=1 during cycle m+1, or `Finished`=1 from m+1.
- Minimum per-instruction period: 2 cycles (processor `Done` on the cycle after `Run`).
- Error asserts `TIMEOUT` cycles after entering WAIT if `Done` has not arrived. `Done` on that same edge wins (completion, no error).
- All outputs are registered. `Resetn` low mid-run forces the reset values immediately, regardless of the clock.

## Test plan
- Load mem[0..4] = 0x240F, 0x0580, 0x247F, 0x6580, 0x4580 with `Prog_len`=5, `Start`; bench model returns `Done` 1 cycle after `Run` (3 cycles for 0x6580 and 0x4580).
  - Expect 5 one-cycle `Run` pulses with `DIN` in that order.
  - Each next `Run` comes 1 cycle after `Done`.
  - `Finished`=1 after the 5th `Done`, `PC`=4.
- `Prog_len`=0, `Start` → `Finished`=1 next cycle, no `Run` pulse.
- Processor never asserts `Done`, `TIMEOUT`=15 → `Err`=1 exactly 15 cycles after the WAIT entry, `DIN`=0; a later `Start` clears `Err` and reruns from `PC`=0.
- `Start` and `Wr_en` pulsed during WAIT → no restart, memory unchanged (read back on a later run); a spurious `Done` in the ISSUE cycle is ignored.
- `Resetn`=0 mid-WAIT between clock edges → all outputs go to 0 immediately; after release, IDLE.
